// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator: h/v counters with decoded sync, data enable,
// pixel coordinates, line/frame strobes, run/stall control, restart and frame counter.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 12
) (
    input  logic          clk25mhz,
    input  logic          rst,
    input  logic          en,
    input  logic          restart,
    output logic [CW-1:0] hori,
    output logic [CW-1:0] verti,
    output logic          de,
    output logic          hs,
    output logic          vs,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        R_ACT,
        R_FP,
        R_SYNC,
        R_BP
    } region_e;

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic [CW-1:0] hori_q, hori_d;
    logic [CW-1:0] verti_q, verti_d;
    logic          de_q, de_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    // Set while the counters are parked at the origin by a held restart, so the
    // origin pulses are emitted once per hold rather than on every cycle.
    logic          sup_q, sup_d;

    region_e h_region, v_region;
    logic    at_origin;
    logic    active;

    // Region "state machines" are pure decodes of the counters; no state register.
    always_comb begin
        if (h_cnt_q < H_ACT_END)       h_region = R_ACT;
        else if (h_cnt_q < H_SYNC_BEG) h_region = R_FP;
        else if (h_cnt_q < H_SYNC_END) h_region = R_SYNC;
        else                           h_region = R_BP;

        if (v_cnt_q < V_ACT_END)       v_region = R_ACT;
        else if (v_cnt_q < V_SYNC_BEG) v_region = R_FP;
        else if (v_cnt_q < V_SYNC_END) v_region = R_SYNC;
        else                           v_region = R_BP;
    end

    always_comb begin
        // NOTE: every signal gets a default before the branches so no latch is inferred.
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (restart) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
            end else begin
                h_cnt_d = h_cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        at_origin     = (h_cnt_q == '0) && (v_cnt_q == '0);
        active        = en || restart;
        hori_d        = hori_q;
        verti_d       = verti_q;
        de_d          = de_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        sup_d         = sup_q;
        if (active) begin
            de_d          = (h_region == R_ACT) && (v_region == R_ACT);
            hori_d        = de_d ? h_cnt_q : '0;
            verti_d       = de_d ? v_cnt_q : '0;
            hs_d          = (h_region == R_SYNC) ? HS_POL : ~HS_POL;
            vs_d          = (v_region == R_SYNC) ? VS_POL : ~VS_POL;
            line_start_d  = (h_cnt_q == '0) && !sup_q;
            frame_start_d = at_origin && !sup_q;
            sup_d         = restart && at_origin;
            if (frame_start_d) frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk25mhz or posedge rst) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hori_q        <= '0;
            verti_q       <= '0;
            de_q          <= 1'b0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            sup_q         <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hori_q        <= hori_d;
            verti_q       <= verti_d;
            de_q          <= de_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            sup_q         <= sup_d;
        end
    end

    assign hori        = hori_q;
    assign verti       = verti_q;
    assign de          = de_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
